dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-requester controller in front of the byte-addressed data RAM (32-bit word view, little-endian, 17-bit byte address space). Arbitrates round-robin between port 0 (core load/store unit) and port 1 (loader/debug port), one transaction in flight. Sequences byte/halfword/word loads with sign/zero extension. Sequences sub-word stores as read-modify-write, because the RAM only writes 4 bytes at once.

Parameters:
WIDTH, 32, address/data width
ADDR_USED, 17, low address bits forwarded to RAM; upper bits ignored

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  reset, asynchronous, active-high
reqN_valid_i  in  1  (N=0,1) request valid
reqN_ready_o  out  1  request accepted this cycle when valid&ready
reqN_we_i  in  1  1=store, 0=load
reqN_size_i  in  2  00 byte, 01 half, 10/11 word
reqN_unsigned_i  in  1  load zero-extend when 1
reqN_addr_i  in  WIDTH  byte address
reqN_wdata_i  in  WIDTH  store data, low lanes used for sub-word
rspN_valid_o  out  1  one-cycle completion pulse (load and store)
rspN_rdata_o  out  WIDTH  extended load data, valid with rspN_valid_o
ram_we_o  out  1  RAM write enable
ram_a_o  out  WIDTH  RAM byte address ({0, addr[ADDR_USED-1:0]})
ram_wd_o  out  WIDTH  RAM write data
ram_rd_i  in  WIDTH  RAM combinational read data (4 bytes from ram_a_o)

Behaviour:
- Reset values:
  - state=IDLE, rr_ptr=0.
  - All ready, rsp_valid and ram_we_o = 0.
  - rsp_rdata, ram_a_o and ram_wd_o = 0.
- FSM states:
  - IDLE → ACCESS on any accepted request.
  - ACCESS → RESP for a load or a word store.
  - ACCESS → WRITE for a byte or half store.
  - WRITE → RESP.
  - RESP → IDLE.
- Arbitration (IDLE only):
  - reqN_ready_o is combinational and asserted only in IDLE, only for the granted port.
  - Only one port is ever granted.
  - Both valid: grant port rr_ptr. One valid: grant it.
  - On each accept, rr_ptr = the other port.
- On accept, latch port id, we, size, unsigned, addr, wdata. Requester inputs are ignored thereafter.
- ACCESS cycle:
  - ram_a_o = latched addr.
  - Load: capture extended data from ram_rd_i.
  - Word store: ram_we_o=1, ram_wd_o=wdata.
  - Sub-word store: ram_we_o=0; capture ram_rd_i into merge register.
- WRITE cycle (sub-word store only):
  - ram_we_o=1, same address.
  - ram_wd_o = merge word with byte 0 (byte) or bytes 0-1 (half) replaced by wdata lanes.
  - Bytes above the store size are rewritten unchanged.
- RESP cycle:
  - rspN_valid_o=1 for the latched port only.
  - rspN_rdata_o = captured load data; 0 for stores.
- Latency from accept edge T:
  - Load and word store: rsp in cycle T+2.
  - Sub-word store: rsp in cycle T+3.
  - Next accept earliest at edge T+3 or T+4 respectively.
- Extension rules:
  - Byte: rd[7:0], sign-extended from bit 7 unless unsigned.
  - Half: rd[15:0], sign-extended from bit 15 unless unsigned.
  - Word: rd unchanged; unsigned ignored.
- No alignment check. Any byte address is legal; the RAM spans 4 consecutive bytes and wraps modulo 2^ADDR_USED.
- ram_we_o is high only in ACCESS (word store) or WRITE. It is never high in IDLE or RESP.
- Reset mid-operation:
  - Returns to IDLE immediately and aborts the transaction with no response.
  - A write already clocked into the RAM stays. A pending WRITE phase is dropped.

Decomposition:
- Package dmem_arb_pkg:
  - size_t enum: SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - state_t enum: IDLE, ACCESS, WRITE, RESP.
  - Lane-mask constants.
- Sub-module dmem_lane_unit (combinational):
  - Load extension: size, unsigned, rd → rdata.
  - Store merge: size, old word, wdata → new word.
- FSM and arbiter stay in dmem_arbiter.

Test Plan:
1. Word store then load:
   - Port0 stores 0xDEADBEEF at 0x100, then loads word from 0x100.
   - Required: RAM bytes 0x100..0x103 = EF,BE,AD,DE; rsp0 at T+2 with rdata 0xDEADBEEF.
2. Signed/unsigned byte loads:
   - Byte at 0x101 = 0xBE.
   - Signed byte load → 0xFFFFFFBE. Unsigned byte load → 0x000000BE.
   - Unsigned half load at 0x102 → 0x0000DEAD.
3. Sub-word stores (RMW):
   - Memory 0xDEADBEEF at 0x100. Byte store wdata 0x12345678 at 0x101.
   - Required: ram_we_o low in ACCESS, high in WRITE. Memory becomes 0xDEAD78EF. rsp at T+3.
   - Half store 0xCAFE at 0x102 → memory 0xCAFE78EF.
4. Contention:
   - Both ports hold valid continuously for 4 transactions.
   - Required: grants alternate 0,1,0,1; never both ready; each rsp on the correct port only.
5. Reset during RMW:
   - Assert rst_i in the WRITE cycle of a byte store.
   - Required: outputs immediately zero, memory unchanged, no rsp pulse, rr_ptr=0.
   - Next request proceeds normally.
6. Address wrap:
   - Word store 0x11223344 at 0x1FFFE.
   - Required: bytes at 0x1FFFE, 0x1FFFF, 0x00000, 0x00001 = 44,33,22,11.
   - Load at 0x1FFFE returns 0x11223344.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
// Size codes, FSM states and load/store lane masks.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WRITE,
    RESP
  } state_t;

  localparam logic [31:0] LANE_B = 32'h0000_00ff;
  localparam logic [31:0] LANE_H = 32'h0000_ffff;

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte-lane logic: load sign/zero extension and sub-word store merge.
// Ports: size, uns, rd, old_word, wdata in; rdata, new_word out.
module dmem_lane_unit
  import dmem_arb_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       size,
  input  logic             uns,
  input  logic [WIDTH-1:0] rd,
  input  logic [WIDTH-1:0] old_word,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] new_word
);

  logic [WIDTH-1:0] mask;

  // Size 2'b11 falls through to the word case.
  always_comb begin
    rdata = rd;
    mask  = '1;
    unique case (1'b1)
      (size == SZ_BYTE): begin
        rdata = {{(WIDTH-8){rd[7] & ~uns}}, rd[7:0]};
        mask  = WIDTH'(LANE_B);
      end
      (size == SZ_HALF): begin
        rdata = {{(WIDTH-16){rd[15] & ~uns}}, rd[15:0]};
        mask  = WIDTH'(LANE_H);
      end
      default: ;
    endcase
  end

  assign new_word = (old_word & ~mask) | (wdata & mask);

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin two-port data RAM controller with sub-word RMW stores.
// Ports: clk_i, rst_i, req0/1_*, rsp0/1_*, ram_we_o/ram_a_o/ram_wd_o, ram_rd_i.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int ADDR_USED = 17
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic             req0_we_i,
  input  logic [1:0]       req0_size_i,
  input  logic             req0_unsigned_i,
  input  logic [WIDTH-1:0] req0_addr_i,
  input  logic [WIDTH-1:0] req0_wdata_i,
  output logic             rsp0_valid_o,
  output logic [WIDTH-1:0] rsp0_rdata_o,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic             req1_we_i,
  input  logic [1:0]       req1_size_i,
  input  logic             req1_unsigned_i,
  input  logic [WIDTH-1:0] req1_addr_i,
  input  logic [WIDTH-1:0] req1_wdata_i,
  output logic             rsp1_valid_o,
  output logic [WIDTH-1:0] rsp1_rdata_o,
  output logic             ram_we_o,
  output logic [WIDTH-1:0] ram_a_o,
  output logic [WIDTH-1:0] ram_wd_o,
  input  logic [WIDTH-1:0] ram_rd_i
);

  state_t               state_q;
  logic                 rr_q;
  logic                 port_q;
  logic                 we_q;
  logic [1:0]           size_q;
  logic                 uns_q;
  logic [ADDR_USED-1:0] addr_q;
  logic [WIDTH-1:0]     wdata_q;
  logic [WIDTH-1:0]     rdata_q;
  logic [WIDTH-1:0]     merge_q;

  logic             idle;
  logic             gnt0;
  logic             gnt1;
  logic [WIDTH-1:0] ext_rd;
  logic [WIDTH-1:0] new_word;
  logic             unused_hi;

  assign unused_hi = ^{req0_addr_i[WIDTH-1:ADDR_USED],
                       req1_addr_i[WIDTH-1:ADDR_USED]};

  // Ready is held low while reset is asserted.
  assign idle = (state_q == IDLE) & ~rst_i;
  assign gnt0 = idle & req0_valid_i & (~req1_valid_i | ~rr_q);
  assign gnt1 = idle & req1_valid_i & (~req0_valid_i | rr_q);

  assign req0_ready_o = gnt0;
  assign req1_ready_o = gnt1;

  dmem_lane_unit #(.WIDTH(WIDTH)) u_lane (
    .size     (size_q),
    .uns      (uns_q),
    .rd       (ram_rd_i),
    .old_word (merge_q),
    .wdata    (wdata_q),
    .rdata    (ext_rd),
    .new_word (new_word)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      merge_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt0 | gnt1) begin
            state_q <= ACCESS;
            port_q  <= gnt1;
            rr_q    <= gnt0;
            we_q    <= gnt1 ? req1_we_i : req0_we_i;
            size_q  <= gnt1 ? req1_size_i : req0_size_i;
            uns_q   <= gnt1 ? req1_unsigned_i : req0_unsigned_i;
            addr_q  <= gnt1 ? req1_addr_i[ADDR_USED-1:0]
                            : req0_addr_i[ADDR_USED-1:0];
            wdata_q <= gnt1 ? req1_wdata_i : req0_wdata_i;
          end
        end
        ACCESS: begin
          rdata_q <= we_q ? '0 : ext_rd;
          merge_q <= ram_rd_i;
          state_q <= (we_q & ~size_q[1]) ? WRITE : RESP;
        end
        WRITE:   state_q <= RESP;
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  logic acc;
  logic wr;
  logic rsp;

  assign acc = (state_q == ACCESS);
  assign wr  = (state_q == WRITE);
  assign rsp = (state_q == RESP);

  assign ram_a_o  = (acc | wr) ? {{(WIDTH-ADDR_USED){1'b0}}, addr_q} : '0;
  assign ram_we_o = (acc & we_q & size_q[1]) | wr;
  assign ram_wd_o = wr ? new_word
                  : (acc & we_q & size_q[1]) ? wdata_q : '0;

  assign rsp0_valid_o = rsp & ~port_q;
  assign rsp1_valid_o = rsp & port_q;
  assign rsp0_rdata_o = rsp0_valid_o ? rdata_q : '0;
  assign rsp1_rdata_o = rsp1_valid_o ? rdata_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a byte-array RAM model.
// Ports: none; drives and checks the arbiter against hand-computed values.
module tb_dmem_arbiter;

  logic        clk_i;
  logic        rst_i;
  logic        v0, r0, we0, u0, rv0;
  logic        v1, r1, we1, u1, rv1;
  logic [1:0]  sz0, sz1;
  logic [31:0] a0, wd0, rd0, a1, wd1, rd1;
  logic        ram_we;
  logic [31:0] ram_a, ram_wd, ram_rd;

  int checks = 0;
  int fails  = 0;

  logic [7:0]  mem [0:131071];
  logic [16:0] ra;

  dmem_arbiter dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .req0_valid_i    (v0),
    .req0_ready_o    (r0),
    .req0_we_i       (we0),
    .req0_size_i     (sz0),
    .req0_unsigned_i (u0),
    .req0_addr_i     (a0),
    .req0_wdata_i    (wd0),
    .rsp0_valid_o    (rv0),
    .rsp0_rdata_o    (rd0),
    .req1_valid_i    (v1),
    .req1_ready_o    (r1),
    .req1_we_i       (we1),
    .req1_size_i     (sz1),
    .req1_unsigned_i (u1),
    .req1_addr_i     (a1),
    .req1_wdata_i    (wd1),
    .rsp1_valid_o    (rv1),
    .rsp1_rdata_o    (rd1),
    .ram_we_o        (ram_we),
    .ram_a_o         (ram_a),
    .ram_wd_o        (ram_wd),
    .ram_rd_i        (ram_rd)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  assign ra = ram_a[16:0];
  assign ram_rd = {mem[ra+17'd3], mem[ra+17'd2],
                   mem[ra+17'd1], mem[ra]};

  always @(posedge clk_i) begin
    if (ram_we) begin
      mem[ra]       <= ram_wd[7:0];
      mem[ra+17'd1] <= ram_wd[15:8];
      mem[ra+17'd2] <= ram_wd[23:16];
      mem[ra+17'd3] <= ram_wd[31:24];
    end
  end

  function automatic logic [31:0] rd_word(input logic [16:0] a);
    return {mem[a+17'd3], mem[a+17'd2], mem[a+17'd1], mem[a]};
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input int p, input logic v, input logic we,
                       input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd);
    if (p == 0) begin
      v0 = v; we0 = we; sz0 = sz; u0 = u; a0 = a; wd0 = wd;
    end else begin
      v1 = v; we1 = we; sz1 = sz; u1 = u; a1 = a; wd1 = wd;
    end
  endtask

  // One transaction; checks RAM strobes, address, latency and response.
  task automatic xact(input string tag, input int p, input logic we,
                      input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] wd,
                      input int exp_lat, input logic [31:0] exp_rd);
    int lat;
    int other;
    logic ok;
    logic [31:0] got_rd;
    logic we_n1, we_n2;
    logic [31:0] a_n1;
    lat = 0; other = 0; ok = 1'b0; got_rd = '0;
    we_n1 = 1'b0; we_n2 = 1'b0; a_n1 = '0;
    @(negedge clk_i);
    drive(p, 1'b1, we, sz, u, a, wd);
    for (int i = 0; i < 20; i++) begin
      #1;
      if ((p == 0) ? r0 : r1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    if (!ok) begin
      check({tag, "_ready"}, 32'd0, 32'd1);
      drive(p, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
      return;
    end
    @(posedge clk_i);
    #1 drive(p, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk_i);
      if (n == 1) begin
        we_n1 = ram_we;
        a_n1 = ram_a;
      end
      if (n == 2) we_n2 = ram_we;
      if (((p == 0) ? rv0 : rv1) && lat == 0) begin
        lat = n;
        got_rd = (p == 0) ? rd0 : rd1;
      end
      if ((p == 0) ? rv1 : rv0) other++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_rdata"}, got_rd, exp_rd);
    check({tag, "_other"}, other, 0);
    check({tag, "_a"}, a_n1, a & 32'h0001_ffff);
    check({tag, "_we_acc"}, {31'd0, we_n1}, {31'd0, we & sz[1]});
    check({tag, "_we_wr"}, {31'd0, we_n2}, {31'd0, we & ~sz[1]});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int cnt;
    int viol;
    int g[$];
    int r[$];
    rst_i = 1'b1;
    drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h100, '0);
    drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h104, '0);
    #12;
    check("rst_ready", {30'd0, r1, r0}, 32'd0);
    check("rst_rsp", {30'd0, rv1, rv0}, 32'd0);
    check("rst_rdata", rd0 | rd1, 32'd0);
    check("rst_ram", {31'd0, ram_we} | ram_a | ram_wd, 32'd0);
    @(negedge clk_i);
    drive(0, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
    rst_i = 1'b0;

    // Word store then load
    xact("sw", 0, 1'b1, 2'b10, 1'b0, 32'h100, 32'hdeadbeef, 2, 32'h0);
    check("b100", {24'd0, mem[17'h100]}, 32'hef);
    check("b101", {24'd0, mem[17'h101]}, 32'hbe);
    check("b102", {24'd0, mem[17'h102]}, 32'had);
    check("b103", {24'd0, mem[17'h103]}, 32'hde);
    xact("lw", 0, 1'b0, 2'b10, 1'b0, 32'h100, '0, 2, 32'hdeadbeef);

    // Extension
    xact("lb", 0, 1'b0, 2'b00, 1'b0, 32'h101, '0, 2, 32'hffffffbe);
    xact("lbu", 1, 1'b0, 2'b00, 1'b1, 32'h101, '0, 2, 32'h000000be);
    xact("lhu", 0, 1'b0, 2'b01, 1'b1, 32'h102, '0, 2, 32'h0000dead);
    xact("lh", 1, 1'b0, 2'b01, 1'b0, 32'h102, '0, 2, 32'hffffdead);
    xact("lwu", 0, 1'b0, 2'b11, 1'b1, 32'h100, '0, 2, 32'hdeadbeef);

    // Sub-word RMW stores
    xact("sb", 0, 1'b1, 2'b00, 1'b0, 32'h101, 32'h12345678, 3, 32'h0);
    check("sb_mem", rd_word(17'h100), 32'hdead78ef);
    xact("sh", 1, 1'b1, 2'b01, 1'b0, 32'h102, 32'hffffcafe, 3, 32'h0);
    check("sh_mem", rd_word(17'h100), 32'hcafe78ef);
    xact("lw2", 0, 1'b0, 2'b10, 1'b0, 32'h100, '0, 2, 32'hcafe78ef);
    xact("sw104", 1, 1'b1, 2'b10, 1'b0, 32'h104, 32'h0badf00d, 2, 32'h0);

    // Reset in the WRITE cycle of a byte store
    @(negedge clk_i);
    drive(0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h100, 32'h55);
    #1 check("mr_ready", {31'd0, r0}, 32'd1);
    @(posedge clk_i);
    #1 drive(0, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
    @(negedge clk_i);
    check("mr_we_acc", {31'd0, ram_we}, 32'd0);
    @(negedge clk_i);
    check("mr_we_wr", {31'd0, ram_we}, 32'd1);
    rst_i = 1'b1;
    #1;
    check("mr_ram", {31'd0, ram_we} | ram_a | ram_wd, 32'd0);
    check("mr_rsp", {30'd0, rv1, rv0}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    check("mr_mem", rd_word(17'h100), 32'hcafe78ef);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      if (rv0 || rv1) cnt++;
    end
    check("mr_norsp", cnt, 0);
    drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h100, '0);
    drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h104, '0);
    #1 check("mr_rr", {30'd0, r1, r0}, 32'd1);
    drive(0, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
    xact("mr_sb", 0, 1'b1, 2'b00, 1'b0, 32'h100, 32'h55, 3, 32'h0);
    check("mr_sb_mem", rd_word(17'h100), 32'hcafe7855);

    // Contention starting from rr_ptr = 0
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    drive(0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h100, '0);
    drive(1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h104, '0);
    viol = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (r0 && r1) viol++;
      if (rv0 && rv1) viol++;
      if (rv0) begin
        r.push_back(0);
        check("c_rd0", rd0, 32'hcafe7855);
      end
      if (rv1) begin
        r.push_back(1);
        check("c_rd1", rd1, 32'h0badf00d);
      end
      if (r0) g.push_back(0);
      if (r1) g.push_back(1);
      if (g.size() == 4) begin
        @(posedge clk_i);
        #1;
        drive(0, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
        break;
      end
      @(negedge clk_i);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      if (rv0 && rv1) viol++;
      if (rv0) begin
        r.push_back(0);
        check("c_rd0", rd0, 32'hcafe7855);
      end
      if (rv1) begin
        r.push_back(1);
        check("c_rd1", rd1, 32'h0badf00d);
      end
    end
    check("c_viol", viol, 0);
    check("c_ngrant", g.size(), 4);
    check("c_nrsp", r.size(), 4);
    if (g.size() == 4 && r.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("c_grant%0d", i), g[i], i % 2);
        check($sformatf("c_rsp%0d", i), r[i], i % 2);
      end
    end

    // Address wrap; upper address bits ignored on the load
    xact("wrap_sw", 0, 1'b1, 2'b10, 1'b0, 32'h0001fffe, 32'h11223344,
         2, 32'h0);
    check("wrap_b0", {24'd0, mem[17'h1fffe]}, 32'h44);
    check("wrap_b1", {24'd0, mem[17'h1ffff]}, 32'h33);
    check("wrap_b2", {24'd0, mem[17'h00000]}, 32'h22);
    check("wrap_b3", {24'd0, mem[17'h00001]}, 32'h11);
    xact("wrap_lw", 1, 1'b0, 2'b10, 1'b0, 32'h8001fffe, '0,
         2, 32'h11223344);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
